// File: rtl/ppwm_prog_tx.sv
// ppwm_prog_tx: serial programming transmitter for the ppwm instruction memory.
// Takes instruction words over valid/ready and sends each one as a frame:
// a high start bit, WIDTH data bits LSB-first, an optional even-parity bit,
// and a low stop bit, with every bit held for BIT_CYCLES clocks. DEPTH words
// make up one session, after which done_o is raised.
// Build option: define PPWM_PROG_TX_PARITY_EN to add the parity bit
// (the frame grows from WIDTH+2 to WIDTH+3 bits).
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   start_i       begin a session (taken only when idle or done)
//   word_i        instruction word, word_valid_i / word_ready_o handshake
//   data_o        registered serial line, idles low
//   busy_o        session in progress
//   done_o        DEPTH words sent; held until start_i or rst
//   word_cnt_o    words fully sent in the current session
module ppwm_prog_tx #(
  parameter int unsigned WIDTH      = 6,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned BIT_CYCLES = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start_i,
  input  logic [WIDTH-1:0]             word_i,
  input  logic                         word_valid_i,
  output logic                         word_ready_o,
  output logic                         data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [$clog2(DEPTH+1)-1:0]   word_cnt_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned BIT_W = $clog2(WIDTH + 1);
  localparam int unsigned DIV_W = $clog2(BIT_CYCLES + 1);

  if (BIT_CYCLES == 0) begin : g_bad_bit_cycles
    $error("ppwm_prog_tx: BIT_CYCLES must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_START,
    S_DATA,
`ifdef PPWM_PROG_TX_PARITY_EN
    S_PAR,
`endif
    S_STOP,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               data_q, data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
`ifdef PPWM_PROG_TX_PARITY_EN
  logic               par_q, par_d;
`endif

  logic               bit_end;
  logic               last_stop;
  logic [CNT_W-1:0]   cnt_inc;
  logic               ready_c;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      data_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PPWM_PROG_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef PPWM_PROG_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Ready in WAIT, and in the final stop cycle when another word still fits
  always_comb begin
    bit_end   = (div_q == DIV_W'(BIT_CYCLES - 1));
    last_stop = (state_q == S_STOP) && bit_end;
    cnt_inc   = cnt_q + CNT_W'(1);
    ready_c   = (state_q == S_WAIT) ||
                (last_stop && (cnt_inc != CNT_W'(DEPTH)));
  end

  assign word_ready_o = ready_c;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    data_d  = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
`ifdef PPWM_PROG_TX_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d = S_WAIT;
          cnt_d   = '0;
        end
      end
      S_WAIT: begin
        if (word_valid_i) begin
          shift_d = word_i;
`ifdef PPWM_PROG_TX_PARITY_EN
          par_d   = ^word_i;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == BIT_W'(WIDTH - 1)) begin
`ifdef PPWM_PROG_TX_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
`ifdef PPWM_PROG_TX_PARITY_EN
      S_PAR: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end && (cnt_q != CNT_W'(DEPTH))) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(DEPTH)) begin
            state_d = S_DONE;
          end else if (word_valid_i) begin
            // back-to-back: next start bit follows the stop bit directly
            shift_d = word_i;
`ifdef PPWM_PROG_TX_PARITY_EN
            par_d   = ^word_i;
`endif
            state_d = S_START;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Bit-period divider runs only while a frame is on the line
    if (state_d != state_q) begin
      div_d = '0;
      bit_d = '0;
    end else if (state_q == S_START || state_q == S_DATA ||
`ifdef PPWM_PROG_TX_PARITY_EN
                 state_q == S_PAR ||
`endif
                 state_q == S_STOP) begin
      div_d = bit_end ? '0 : div_q + DIV_W'(1);
    end

    // Line level is registered from the state being entered
    unique case (state_d)
      S_START: data_d = 1'b1;
      S_DATA:  data_d = shift_d[0];
`ifdef PPWM_PROG_TX_PARITY_EN
      S_PAR:   data_d = par_d;
`endif
      default: data_d = 1'b0;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  assign data_o     = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign word_cnt_o = cnt_q;

endmodule

// File: tb/tb_ppwm_prog_tx.sv
module tb_ppwm_prog_tx;

`ifdef PPWM_PROG_TX_PARITY_EN
  localparam int FB = 9;
`else
  localparam int FB = 8;
`endif

  logic       clk;
  logic       rst;
  logic       start_i, word_valid_i, word_ready_o, data_o, busy_o, done_o;
  logic [5:0] word_i;
  logic [5:0] word_cnt_o;
  logic       start3, valid3, ready3, data3, busy3, done3;
  logic [5:0] word3;
  logic [5:0] cnt3;

  int n_pass;
  int n_total;
  int exp_cnt;

  ppwm_prog_tx #(.WIDTH(6), .DEPTH(32), .BIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .word_i(word_i),
    .word_valid_i(word_valid_i), .word_ready_o(word_ready_o), .data_o(data_o),
    .busy_o(busy_o), .done_o(done_o), .word_cnt_o(word_cnt_o)
  );

  ppwm_prog_tx #(.WIDTH(6), .DEPTH(32), .BIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .start_i(start3), .word_i(word3),
    .word_valid_i(valid3), .word_ready_o(ready3), .data_o(data3),
    .busy_o(busy3), .done_o(done3), .word_cnt_o(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] word;
    logic       par;    // hand-computed even parity of word
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Frame in time order: bit 0 is the first bit on the line
  function automatic logic [FB-1:0] mk_frame(input logic [5:0] w, input logic p);
    logic [FB-1:0] f;
    f = '0;
    f[0] = 1'b1;
    for (int i = 0; i < 6; i++) f[1+i] = w[i];
`ifdef PPWM_PROG_TX_PARITY_EN
    f[7] = p;
`else
    if (p) f[7] = 1'b0;
`endif
    f[FB-1] = 1'b0;
    return f;
  endfunction

  task automatic pulse_start();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  // Called at a negedge in WAIT; returns at the negedge after the stop bit
  task automatic send_word(input string nm, input logic [5:0] w, input logic p,
                           input bit start_mid);
    logic [FB-1:0] got;
    word_i       = w;
    word_valid_i = 1'b1;
    chk({nm, "_ready"}, 64'(word_ready_o), 64'd1);
    @(negedge clk);
    word_valid_i = 1'b0;
    word_i       = ~w;
    got[0]       = data_o;
    for (int i = 1; i < FB; i++) begin
      if (start_mid && i == 3) start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      got[i]  = data_o;
    end
    @(negedge clk);
    exp_cnt++;
    chk({nm, "_frame"}, 64'(got), 64'(mk_frame(w, p)));
    chk({nm, "_cnt"}, 64'(word_cnt_o), 64'(exp_cnt));
    chk({nm, "_idle_low"}, 64'(data_o), 64'd0);
  endtask

  initial begin
    int mism;
    logic [FB-1:0] fr;
    logic [3*FB-1:0] got3, exp3;

    n_pass = 0; n_total = 0; exp_cnt = 0;
    rst = 1'b1; start_i = 1'b0; word_i = '0; word_valid_i = 1'b0;
    start3 = 1'b0; word3 = '0; valid3 = 1'b0;

    vecs[0] = '{6'b101101, 1'b0};
    vecs[1] = '{6'b000111, 1'b1};
    vecs[2] = '{6'b111111, 1'b0};
    vecs[3] = '{6'b000000, 1'b0};
    vecs[4] = '{6'b100000, 1'b1};
    vecs[5] = '{6'b010101, 1'b1};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_outs", 64'({word_ready_o, data_o, busy_o, done_o}), 64'd0);
    chk("rst_cnt", 64'(word_cnt_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    chk("start_state", 64'({word_ready_o, busy_o, done_o}), 64'b110);

    // Table-driven frames, one word at a time
    foreach (vecs[k]) send_word($sformatf("vec%0d", k), vecs[k].word, vecs[k].par, 1'b0);

    // start_i mid-frame is ignored
    send_word("start_busy", 6'b110010, 1'b1, 1'b1);
    chk("start_busy_ready", 64'(word_ready_o), 64'd1);

    // Asynchronous reset mid-DATA
    word_i = 6'b111111; word_valid_i = 1'b1;
    @(negedge clk);
    word_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_data", 64'(data_o), 64'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_data", 64'(data_o), 64'd0);
    chk("async_rst_busy_cnt", 64'({busy_o, word_cnt_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pulse_start();
    exp_cnt = 0;
    chk("restart_state", 64'({word_ready_o, busy_o, word_cnt_o}), 64'({2'b11, 6'd0}));

    // 32 back-to-back words, valid held high throughout
    word_i = 6'b101101; word_valid_i = 1'b1;
    fr = mk_frame(6'b101101, 1'b0);
    mism = 0;
    for (int c = 1; c <= 32 * FB; c++) begin
      @(negedge clk);
      if (data_o !== fr[(c-1) % FB]) mism++;
      if ((c % FB == 0) && (c < 32 * FB) && (word_ready_o !== 1'b1)) mism++;
      if ((c % FB == 1) && (c > 1) && (word_cnt_o !== 6'((c-1) / FB))) mism++;
    end
    chk("b2b_stream_errs", 64'(mism), 64'd0);
    chk("b2b_last_stop", 64'({done_o, word_ready_o}), 64'd0);
    @(negedge clk);
    chk("b2b_done", 64'({done_o, busy_o, word_ready_o, data_o}), 64'b1000);
    chk("b2b_cnt", 64'(word_cnt_o), 64'd32);
    repeat (3) @(negedge clk);
    chk("done_saturate", 64'({done_o, word_cnt_o}), 64'({1'b1, 6'd32}));
    word_valid_i = 1'b0;
    pulse_start();
    chk("start_in_done", 64'({done_o, word_ready_o, word_cnt_o}), 64'({2'b01, 6'd0}));

    // BIT_CYCLES=3 instance: every bit held three clocks
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    word3 = 6'h3F; valid3 = 1'b1;
    chk("bc3_ready", 64'(ready3), 64'd1);
    @(negedge clk);
    valid3 = 1'b0; word3 = 6'h00;
    fr = mk_frame(6'h3F, 1'b0);
    for (int i = 0; i < 3 * FB; i++) begin
      exp3[i] = fr[i / 3];
      got3[i] = data3;
      if (i < 3 * FB - 1) @(negedge clk);
    end
    chk("bc3_frame", 64'(got3), 64'(exp3));
    chk("bc3_cnt_in_stop", 64'(cnt3), 64'd0);
    @(negedge clk);
    chk("bc3_cnt", 64'(cnt3), 64'd1);
    chk("bc3_idle", 64'({data3, ready3, busy3}), 64'b011);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
